sd_access_scheduler: RTL and testbench

- Sits between the application (sector writer and sector reader clients) and sd_spi_controller's wr_start_en/rd_start_en interface.
- Arbitrates read and write requests, each a multi-sector burst, using round-robin priority.
- Issues one start pulse per sector with an auto-incremented sector address and tracks controller busy to sequence sectors.
- Reports per-burst completion and errors back to each client.

---
 rtl/sd_access_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_sd_access_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_access_scheduler.sv
// sd_access_scheduler: round-robin arbiter that turns multi-sector read/write bursts into
// per-sector start pulses for the SD SPI controller. Macro SD_SCHED_TIMEOUT_EN adds a busy watchdog.
module sd_access_scheduler #(
    parameter int CNT_W       = 16,
    parameter int BUSY_WAIT   = 64,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic             clk_sd,
    input  logic             reset,
    input  logic             sd_init_done,
    input  logic             wr_req,
    input  logic [31:0]      wr_base_addr,
    input  logic [CNT_W-1:0] wr_sec_cnt,
    output logic             wr_done,
    output logic             wr_err,
    input  logic             rd_req,
    input  logic [31:0]      rd_base_addr,
    input  logic [CNT_W-1:0] rd_sec_cnt,
    output logic             rd_done,
    output logic             rd_err,
    output logic             ctl_wr_start_en,
    output logic [31:0]      ctl_wr_sec_addr,
    input  logic             ctl_wr_busy,
    output logic             ctl_rd_start_en,
    output logic [31:0]      ctl_rd_sec_addr,
    input  logic             ctl_rd_busy,
    output logic             sched_busy,
    output logic             cur_is_wr
);

    // state     | meaning
    // IDLE      | waiting for a request with init done
    // START     | one-cycle start pulse for the current sector
    // WAIT_BUSY | waiting for controller busy to rise (bounded by BUSY_WAIT)
    // WAIT_DONE | waiting for controller busy to fall
    // NEXT      | advance address/count, decide next sector or finish
    // FINISH    | done pulse, flip round-robin pointer
    // ERROR     | err pulse, flip round-robin pointer
    typedef enum logic [2:0] {
        IDLE, START, WAIT_BUSY, WAIT_DONE, NEXT, FINISH, ERROR
    } state_t;

    localparam int BW_W = $clog2(BUSY_WAIT + 1);

    state_t           state, state_d;
    logic             is_wr, is_wr_d;
    logic             prefer_wr, prefer_wr_d;
    logic [31:0]      addr, addr_d;
    logic [31:0]      wr_addr_q, rd_addr_q;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [BW_W-1:0]  bw_tmr, bw_tmr_d;
    logic             grant_wr, req_cur, busy_cur, err_hold;

    assign grant_wr = wr_req && (!rd_req || prefer_wr);
    assign req_cur  = is_wr ? wr_req : rd_req;
    assign busy_cur = is_wr ? ctl_wr_busy : ctl_rd_busy;

`ifdef SD_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_tmr, to_tmr_d;
    logic            hold_q, hold_d;

    // hold_q keeps ERROR silent until the stuck controller finally drops busy
    always_ff @(posedge clk_sd or posedge reset) begin
        if (reset) begin
            to_tmr <= '0;
            hold_q <= 1'b0;
        end else begin
            to_tmr <= to_tmr_d;
            hold_q <= hold_d;
        end
    end

    assign err_hold = hold_q;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign err_hold = 1'b0;
`endif

    always_ff @(posedge clk_sd or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            is_wr     <= 1'b0;
            prefer_wr <= 1'b1;
            addr      <= '0;
            cnt       <= '0;
            bw_tmr    <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
        end else begin
            state     <= state_d;
            is_wr     <= is_wr_d;
            prefer_wr <= prefer_wr_d;
            addr      <= addr_d;
            cnt       <= cnt_d;
            bw_tmr    <= bw_tmr_d;
            // sector address outputs only move when a new start pulse begins
            if (state_d == START) begin
                if (is_wr_d) wr_addr_q <= addr_d;
                else         rd_addr_q <= addr_d;
            end
        end
    end

    always_comb begin
        state_d     = state;
        is_wr_d     = is_wr;
        prefer_wr_d = prefer_wr;
        addr_d      = addr;
        cnt_d       = cnt;
        bw_tmr_d    = bw_tmr;
`ifdef SD_SCHED_TIMEOUT_EN
        to_tmr_d    = to_tmr;
        hold_d      = hold_q;
`endif
        case (state)
            IDLE: begin
                if (sd_init_done && (wr_req || rd_req)) begin
                    is_wr_d = grant_wr;
                    addr_d  = grant_wr ? wr_base_addr : rd_base_addr;
                    cnt_d   = grant_wr ? wr_sec_cnt : rd_sec_cnt;
                    state_d = (cnt_d == '0) ? ERROR : START;
                end
            end
            START: begin
                bw_tmr_d = BW_W'(BUSY_WAIT);
                state_d  = sd_init_done ? WAIT_BUSY : ERROR;
            end
            WAIT_BUSY: begin
                if (!sd_init_done) begin
                    state_d = ERROR;
                end else if (busy_cur) begin
                    state_d = WAIT_DONE;
`ifdef SD_SCHED_TIMEOUT_EN
                    to_tmr_d = TO_W'(TIMEOUT_CYC);
`endif
                end else if (bw_tmr <= BW_W'(1)) begin
                    state_d = ERROR;
                end else begin
                    bw_tmr_d = bw_tmr - BW_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!sd_init_done) begin
                    state_d = ERROR;
                end else if (!busy_cur) begin
                    state_d = NEXT;
`ifdef SD_SCHED_TIMEOUT_EN
                end else if (to_tmr <= TO_W'(1)) begin
                    state_d = ERROR;
                    hold_d  = 1'b1;
                end else begin
                    to_tmr_d = to_tmr - TO_W'(1);
`endif
                end
            end
            NEXT: begin
                // a dropped request is only acted on here, after the sector has finished
                if (!sd_init_done || !req_cur) begin
                    state_d = ERROR;
                end else begin
                    cnt_d   = cnt - CNT_W'(1);
                    addr_d  = addr + 32'd1;
                    state_d = (cnt == CNT_W'(1)) ? FINISH : START;
                end
            end
            FINISH: begin
                prefer_wr_d = !prefer_wr;
                state_d     = IDLE;
            end
            ERROR: begin
`ifdef SD_SCHED_TIMEOUT_EN
                if (hold_q) begin
                    if (!busy_cur) hold_d = 1'b0;
                end else begin
                    prefer_wr_d = !prefer_wr;
                    state_d     = IDLE;
                end
`else
                prefer_wr_d = !prefer_wr;
                state_d     = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign sched_busy      = (state != IDLE);
    assign cur_is_wr       = is_wr && sched_busy;
    assign ctl_wr_start_en = (state == START) && is_wr;
    assign ctl_rd_start_en = (state == START) && !is_wr;
    assign ctl_wr_sec_addr = wr_addr_q;
    assign ctl_rd_sec_addr = rd_addr_q;
    assign wr_done         = (state == FINISH) && is_wr;
    assign rd_done         = (state == FINISH) && !is_wr;
    assign wr_err          = (state == ERROR) && is_wr && !err_hold;
    assign rd_err          = (state == ERROR) && !is_wr && !err_hold;

endmodule

// File: tb/tb_sd_access_scheduler.sv
// tb_sd_access_scheduler: directed bench for sd_access_scheduler with a simple controller busy model.
module tb_sd_access_scheduler;
    localparam int CNT_W = 16;

    logic             clk_sd = 1'b0;
    logic             reset;
    logic             sd_init_done;
    logic             wr_req, rd_req;
    logic [31:0]      wr_base_addr, rd_base_addr;
    logic [CNT_W-1:0] wr_sec_cnt, rd_sec_cnt;
    logic             wr_done, wr_err, rd_done, rd_err;
    logic             ctl_wr_start_en, ctl_rd_start_en;
    logic [31:0]      ctl_wr_sec_addr, ctl_rd_sec_addr;
    logic             ctl_wr_busy = 1'b0;
    logic             ctl_rd_busy = 1'b0;
    logic             sched_busy, cur_is_wr;

    sd_access_scheduler #(.CNT_W(CNT_W), .BUSY_WAIT(64), .TIMEOUT_CYC(100)) dut (
        .clk_sd(clk_sd), .reset(reset), .sd_init_done(sd_init_done),
        .wr_req(wr_req), .wr_base_addr(wr_base_addr), .wr_sec_cnt(wr_sec_cnt),
        .wr_done(wr_done), .wr_err(wr_err),
        .rd_req(rd_req), .rd_base_addr(rd_base_addr), .rd_sec_cnt(rd_sec_cnt),
        .rd_done(rd_done), .rd_err(rd_err),
        .ctl_wr_start_en(ctl_wr_start_en), .ctl_wr_sec_addr(ctl_wr_sec_addr), .ctl_wr_busy(ctl_wr_busy),
        .ctl_rd_start_en(ctl_rd_start_en), .ctl_rd_sec_addr(ctl_rd_sec_addr), .ctl_rd_busy(ctl_rd_busy),
        .sched_busy(sched_busy), .cur_is_wr(cur_is_wr)
    );

    always #5 clk_sd = ~clk_sd;

    int          vectors = 0;
    int          miscompares = 0;
    int          busy_len = 20;
    bit          busy_en = 1'b1;
    bit          busy_release = 1'b0;
    int          wr_left = 0, rd_left = 0;
    int          wr_done_n = 0, wr_err_n = 0, rd_done_n = 0, rd_err_n = 0;
    logic [31:0] wr_log[$];
    logic [31:0] rd_log[$];

    // controller model: busy rises on the start pulse and stays high busy_len cycles
    always @(negedge clk_sd) begin
        if (busy_release && wr_left > 1) wr_left = 1;
        if (wr_left > 0) begin
            wr_left--;
            if (wr_left == 0) ctl_wr_busy = 1'b0;
        end
        if (rd_left > 0) begin
            rd_left--;
            if (rd_left == 0) ctl_rd_busy = 1'b0;
        end
        if (ctl_wr_start_en) begin
            wr_log.push_back(ctl_wr_sec_addr);
            if (busy_en) begin
                ctl_wr_busy = 1'b1;
                wr_left     = busy_len;
            end
        end
        if (ctl_rd_start_en) begin
            rd_log.push_back(ctl_rd_sec_addr);
            if (busy_en) begin
                ctl_rd_busy = 1'b1;
                rd_left     = busy_len;
            end
        end
        if (ctl_wr_start_en || ctl_rd_start_en) begin
            vectors++;
            assert (!(ctl_wr_start_en && ctl_rd_start_en)) else begin
                miscompares++;
                $error("FAIL start_exclusive observed=both expected=one");
            end
        end
        if (wr_done) wr_done_n++;
        if (wr_err)  wr_err_n++;
        if (rd_done) rd_done_n++;
        if (rd_err)  rd_err_n++;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sd);
    endtask

    function automatic logic pick(input int which);
        case (which)
            0:       return wr_done;
            1:       return wr_err;
            2:       return rd_done;
            3:       return rd_err;
            4:       return ctl_wr_busy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_out(input int which, input int lim, input string tag);
        int n = 0;
        while (!pick(which) && n < lim) begin
            @(negedge clk_sd);
            n++;
        end
        check(tag, 32'(pick(which)), 32'd1);
    endtask

    initial begin
        reset = 1'b1; sd_init_done = 1'b1;
        wr_req = 1'b0; rd_req = 1'b0;
        wr_base_addr = '0; rd_base_addr = '0; wr_sec_cnt = '0; rd_sec_cnt = '0;
        tick(2);
        check("rst_flags", 32'({sched_busy, cur_is_wr, ctl_wr_start_en, ctl_rd_start_en,
                                wr_done, wr_err, rd_done, rd_err}), 32'd0);
        check("rst_wr_addr", ctl_wr_sec_addr, 32'd0);
        check("rst_rd_addr", ctl_rd_sec_addr, 32'd0);
        reset = 1'b0;
        tick(1);

        // three-sector write burst
        wr_base_addr = 32'h100; wr_sec_cnt = 16'd3; wr_req = 1'b1;
        tick(1);
        check("t1_start", 32'(ctl_wr_start_en), 32'd1);
        check("t1_addr0", ctl_wr_sec_addr, 32'h100);
        check("t1_cur_is_wr", 32'(cur_is_wr), 32'd1);
        wait_out(0, 300, "t1_done");
        wr_req = 1'b0;
        tick(1);
        check("t1_done_pulse", 32'(wr_done), 32'd0);
        check("t1_nstarts", 32'(wr_log.size()), 32'd3);
        check("t1_log1", wr_log[1], 32'h101);
        check("t1_log2", wr_log[2], 32'h102);
        check("t1_addr_held", ctl_wr_sec_addr, 32'h102);
        check("t1_no_rd", 32'(rd_log.size()), 32'd0);
        check("t1_done_n", 32'(wr_done_n), 32'd1);

        // zero-length read: err without a start pulse
        rd_base_addr = 32'h55; rd_sec_cnt = 16'd0; rd_req = 1'b1;
        tick(1);
        check("z_err", 32'(rd_err), 32'd1);
        check("z_nostart", 32'(ctl_rd_start_en), 32'd0);
        rd_req = 1'b0;
        tick(1);
        check("z_idle", 32'(sched_busy), 32'd0);
        check("z_addr_untouched", ctl_rd_sec_addr, 32'd0);

        // simultaneous pair, write favoured
        wr_base_addr = 32'h200; wr_sec_cnt = 16'd1;
        rd_base_addr = 32'h300; rd_sec_cnt = 16'd1;
        wr_req = 1'b1; rd_req = 1'b1;
        tick(1);
        check("p1_wr_first", 32'({ctl_wr_start_en, ctl_rd_start_en}), 32'd2);
        wait_out(0, 100, "p1_wr_done");
        wr_req = 1'b0;
        wait_out(2, 200, "p1_rd_done");
        rd_req = 1'b0;
        tick(1);
        check("p1_wr_addr", wr_log[3], 32'h200);
        check("p1_rd_addr", rd_log[0], 32'h300);

        // read burst across the 32-bit address wrap
        rd_base_addr = 32'hFFFF_FFFF; rd_sec_cnt = 16'd2; rd_req = 1'b1;
        wait_out(2, 200, "wrap_done");
        rd_req = 1'b0;
        tick(1);
        check("wrap_n", 32'(rd_log.size()), 32'd3);
        check("wrap_a0", rd_log[1], 32'hFFFF_FFFF);
        check("wrap_a1", rd_log[2], 32'h0000_0000);
        check("wrap_done_n", 32'(rd_done_n), 32'd2);

        // busy never rises: err 65 cycles after the start pulse
        busy_en = 1'b0;
        wr_base_addr = 32'h400; wr_sec_cnt = 16'd1; wr_req = 1'b1;
        tick(1);
        check("bw_start", 32'(ctl_wr_start_en), 32'd1);
        tick(64);
        check("bw_no_err_64", 32'(wr_err), 32'd0);
        tick(1);
        check("bw_err_65", 32'(wr_err), 32'd1);
        wr_req = 1'b0;
        tick(1);
        check("bw_idle", 32'(sched_busy), 32'd0);
        busy_en = 1'b1;

        wr_base_addr = 32'h500; wr_sec_cnt = 16'd1; wr_req = 1'b1;
        wait_out(0, 100, "fu_done");
        wr_req = 1'b0;
        tick(1);
        check("fu_addr", wr_log[5], 32'h500);

        // second simultaneous pair, read favoured now
        wr_base_addr = 32'h600; rd_base_addr = 32'h700;
        wr_req = 1'b1; rd_req = 1'b1;
        tick(1);
        check("p2_rd_first", 32'({ctl_wr_start_en, ctl_rd_start_en}), 32'd1);
        check("p2_rd_addr", ctl_rd_sec_addr, 32'h700);
        wait_out(2, 100, "p2_rd_done");
        rd_req = 1'b0;
        wait_out(0, 200, "p2_wr_done");
        wr_req = 1'b0;
        tick(1);
        check("p2_wr_addr", wr_log[6], 32'h600);

        // request dropped mid-sector: sector completes, then err
        wr_base_addr = 32'h900; wr_sec_cnt = 16'd3; wr_req = 1'b1;
        wait_out(4, 20, "drop_busy");
        tick(3);
        wr_req = 1'b0;
        wait_out(1, 100, "drop_err");
        check("drop_ctl_idle", 32'(ctl_wr_busy), 32'd0);
        tick(1);
        check("drop_nstarts", 32'(wr_log.size()), 32'd8);
        check("drop_idle", 32'(sched_busy), 32'd0);

        // init gating and init loss mid-burst
        sd_init_done = 1'b0;
        wr_base_addr = 32'hA00; wr_sec_cnt = 16'd2; wr_req = 1'b1;
        tick(5);
        check("ini_hold", 32'(sched_busy), 32'd0);
        check("ini_nostart", 32'(wr_log.size()), 32'd8);
        sd_init_done = 1'b1;
        tick(1);
        check("ini_start", 32'(ctl_wr_start_en), 32'd1);
        check("ini_addr", ctl_wr_sec_addr, 32'hA00);
        wait_out(4, 20, "ini_busy");
        sd_init_done = 1'b0;
        tick(1);
        check("ini_err", 32'(wr_err), 32'd1);
        wr_req = 1'b0;
        tick(1);
        check("ini_idle", 32'(sched_busy), 32'd0);
        check("wr_done_total", 32'(wr_done_n), 32'd4);
        check("wr_err_total", 32'(wr_err_n), 32'd3);
        tick(30);

`ifdef SD_SCHED_TIMEOUT_EN
        // stuck busy: ERROR is held silently until busy is released
        sd_init_done = 1'b1; busy_len = 10000;
        wr_base_addr = 32'hB00; wr_sec_cnt = 16'd1; wr_req = 1'b1;
        tick(120);
        check("to_held", 32'(sched_busy), 32'd1);
        check("to_no_err", 32'(wr_err), 32'd0);
        busy_release = 1'b1;
        wait_out(1, 10, "to_err");
        wr_req = 1'b0;
        tick(1);
        check("to_idle", 32'(sched_busy), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
